// File: rtl/pll_mon_pkg.sv
// Shared constants for the PLL lock monitor.
// Contents:
//   ST_*         state encodings reported on state_o
//   DEF_*        default parameter values
//   max3         helper for sizing the shared phase timer
package pll_mon_pkg;

  localparam logic [1:0] ST_PLLRST = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_LOCK_STABLE    = 1024;
  localparam int unsigned DEF_LOSS_FILTER    = 4;
  localparam int unsigned DEF_CNT_W          = 8;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   destination clock
//   rst   synchronous active-high reset, clears both flops to 0
//   d     asynchronous input
//   q     synchronized output, d delayed by two clk edges
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL supervisor running on the PLL reference clock. Pulses the PLL reset, waits for lock,
// qualifies it for LOCK_STABLE cycles, then releases the system reset. Retries on lock timeout
// and re-resets everything on a filtered lock loss.
// Ports:
//   clkin          reference clock (same net as PLL CLKIN)
//   reset          synchronous active-high block reset
//   pll_lock       PLL lock output, asynchronous
//   pll_reset      registered drive to the PLL reset input
//   sys_rst        registered active-high system reset
//   locked_stable  high only in RUN
//   retry_cnt      saturating count of lock timeouts
//   loss_cnt       saturating count of lock losses seen in RUN
//   state_o        current state encoding
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned LOSS_FILTER    = DEF_LOSS_FILTER,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             sys_rst,
  output logic             locked_stable,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state_o
);

  // The timer only ever reaches (limit - 1) before being cleared on a state change.
  localparam int unsigned TimerMax = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam int unsigned FiltW    = $clog2(LOSS_FILTER + 1);

  logic              lock_s;
  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [FiltW-1:0]  filt_q, filt_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic              pll_reset_q, sys_rst_q, locked_q;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    filt_d  = filt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_PLLRST: begin
        // Lock is meaningless while the PLL is held in reset.
        if (timer_q == TimerW'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      ST_WAIT: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_PLLRST;
          timer_d = '0;
          if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end else if (timer_q == TimerW'(LOCK_STABLE - 1)) begin
          state_d = ST_RUN;
          timer_d = '0;
          filt_d  = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      ST_RUN: begin
        if (lock_s) begin
          filt_d = '0;
        end else if (filt_q == FiltW'(LOSS_FILTER - 1)) begin
          // This sample completes LOSS_FILTER consecutive lows.
          state_d = ST_PLLRST;
          timer_d = '0;
          filt_d  = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else begin
          filt_d = filt_q + FiltW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_PLLRST;
      timer_q     <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      filt_q      <= filt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      // Outputs are registered from the next state so they change on the transition edge.
      pll_reset_q <= (state_d == ST_PLLRST);
      sys_rst_q   <= (state_d != ST_RUN);
      locked_q    <= (state_d == ST_RUN);
    end
  end

  assign pll_reset     = pll_reset_q;
  assign sys_rst       = sys_rst_q;
  assign locked_stable = locked_q;
  assign retry_cnt     = retry_q;
  assign loss_cnt      = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized bench for pll_lock_monitor: two DUTs (CNT_W=8 and CNT_W=2) share the stimulus and
// are compared every cycle against a phase/elapsed-cycle reference model, plus directed checks.
module tb_pll_lock_monitor;

  localparam int unsigned PRC = 4;
  localparam int unsigned LTO = 20;
  localparam int unsigned LST = 8;
  localparam int unsigned LF  = 3;

  localparam int PH_PLLRST = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic lock = 1'b0;

  logic       pr8, sr8, lk8;
  logic [7:0] rc8, lc8;
  logic [1:0] st8;
  logic       pr2, sr2, lk2;
  logic [1:0] rc2, lc2;
  logic [1:0] st2;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LTO),
    .LOCK_STABLE    (LST),
    .LOSS_FILTER    (LF),
    .CNT_W          (8)
  ) dut (
    .clkin         (clk),
    .reset         (rst),
    .pll_lock      (lock),
    .pll_reset     (pr8),
    .sys_rst       (sr8),
    .locked_stable (lk8),
    .retry_cnt     (rc8),
    .loss_cnt      (lc8),
    .state_o       (st8)
  );

  pll_lock_monitor #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LTO),
    .LOCK_STABLE    (LST),
    .LOSS_FILTER    (LF),
    .CNT_W          (2)
  ) dut_w2 (
    .clkin         (clk),
    .reset         (rst),
    .pll_lock      (lock),
    .pll_reset     (pr2),
    .sys_rst       (sr2),
    .locked_stable (lk2),
    .retry_cnt     (rc2),
    .loss_cnt      (lc2),
    .state_o       (st2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase, edges elapsed in the phase, trailing lows seen in RUN, event totals.
  int m_phase, m_n, m_lows, m_retry, m_loss;
  bit m_pipe[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge(input bit l, input bit r);
    bit ls;
    if (r) begin
      m_phase = PH_PLLRST;
      m_n     = 0;
      m_lows  = 0;
      m_retry = 0;
      m_loss  = 0;
      m_pipe.delete();
      m_pipe.push_back(1'b0);
      m_pipe.push_back(1'b0);
    end else begin
      // Lock seen by the monitor is the pin value from two edges earlier.
      ls = m_pipe.pop_front();
      m_pipe.push_back(l);
      m_n++;
      case (m_phase)
        PH_PLLRST: if (m_n == PRC) begin m_phase = PH_WAIT; m_n = 0; end
        PH_WAIT: begin
          if (ls) begin
            m_phase = PH_STABLE; m_n = 0;
          end else if (m_n == LTO) begin
            m_phase = PH_PLLRST; m_n = 0; m_retry++;
          end
        end
        PH_STABLE: begin
          if (!ls) begin
            m_phase = PH_WAIT; m_n = 0;
          end else if (m_n == LST) begin
            m_phase = PH_RUN; m_n = 0; m_lows = 0;
          end
        end
        default: begin
          m_lows = ls ? 0 : m_lows + 1;
          if (m_lows == LF) begin
            m_phase = PH_PLLRST; m_n = 0; m_loss++;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("pll_reset", pr8, m_phase == PH_PLLRST);
    check_eq("sys_rst", sr8, m_phase != PH_RUN);
    check_eq("locked_stable", lk8, m_phase == PH_RUN);
    check_eq("state", st8, m_phase);
    check_eq("retry_cnt", rc8, sat(m_retry, 8));
    check_eq("loss_cnt", lc8, sat(m_loss, 8));
    check_eq("w2_pll_reset", pr2, m_phase == PH_PLLRST);
    check_eq("w2_sys_rst", sr2, m_phase != PH_RUN);
    check_eq("w2_locked_stable", lk2, m_phase == PH_RUN);
    check_eq("w2_state", st2, m_phase);
    check_eq("w2_retry_cnt", rc2, sat(m_retry, 2));
    check_eq("w2_loss_cnt", lc2, sat(m_loss, 2));
  endtask

  task automatic step(input bit l, input bit r);
    @(negedge clk);
    lock = l;
    rst  = r;
    @(posedge clk);
    model_edge(l, r);
    #1;
    compare_all();
  endtask

  int rv, len, iter;

  initial begin
    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_eq("rst_state", st8, 0);
    check_eq("rst_pll_reset", pr8, 1);
    check_eq("rst_sys_rst", sr8, 1);
    check_eq("rst_locked", lk8, 0);

    // Lock rises in time for edge 6 and stays high.
    for (int e = 0; e <= 20; e++) begin
      step(e >= 6, 1'b0);
      if (e == 2)  check_eq("s1_pll_reset_hi", pr8, 1);
      if (e == 4)  check_eq("s1_pll_reset_lo", pr8, 0);
      if (e == 15) check_eq("s1_sys_rst_hi", sr8, 1);
      if (e == 16) begin
        check_eq("s1_sys_rst_lo", sr8, 0);
        check_eq("s1_locked", lk8, 1);
      end
      if (e == 20) check_eq("s1_retry", rc8, 0);
    end

    // RUN: 1- and 2-cycle glitches are filtered, a 3-cycle low is a loss.
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("s4_g1_state", st8, 3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("s4_g2_state", st8, 3);
    check_eq("s4_g2_loss", lc8, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("s4_pre_state", st8, 3);
    step(1'b1, 1'b0);
    check_eq("s4_state", st8, 0);
    check_eq("s4_sys_rst", sr8, 1);
    check_eq("s4_pll_reset", pr8, 1);
    check_eq("s4_loss", lc8, 1);

    // Back to RUN, then reset mid-RUN.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check_eq("s5_run", st8, 3);
    step(1'b1, 1'b1);
    check_eq("s5_state", st8, 0);
    check_eq("s5_sys_rst", sr8, 1);
    check_eq("s5_pll_reset", pr8, 1);
    check_eq("s5_loss", lc8, 0);
    check_eq("s5_retry", rc8, 0);

    // One-cycle drop during STABLE requalifies from scratch.
    iter = 0;
    while (m_phase != PH_STABLE && iter < 50) begin
      step(1'b1, 1'b0);
      iter++;
    end
    check_eq("s3_reach_stable", m_phase, PH_STABLE);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      step(1'b1, 1'b0);
      if (j == 9)  check_eq("s3_sys_rst_hi", sr8, 1);
      if (j == 10) check_eq("s3_sys_rst_lo", sr8, 0);
    end
    check_eq("s3_retry", rc8, 0);

    // Lock never arrives: periodic retries, narrow counter saturates.
    step(1'b0, 1'b1);
    for (int e = 0; e < 200; e++) begin
      step(1'b0, 1'b0);
      if (e == 59) begin
        check_eq("s2_retry", rc8, 2);
        check_eq("s2_sys_rst", sr8, 1);
      end
    end
    check_eq("s6_retry_w2", rc2, 3);
    check_eq("s6_retry_w8", rc8, 8);

    // Random lock waveform with occasional resets.
    step(1'b0, 1'b1);
    for (int blk = 0; blk < 250; blk++) begin
      rv  = ($urandom_range(0, 99) < 60) ? 1 : 0;
      len = (rv == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                   : $urandom_range(1, 30);
      for (int i = 0; i < len; i++) step(rv[0], $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
